match_controller: RTL
=====================

# match_controller

Sequences a two-player match for the scoring/LED block: waits for a start press, times the serve, and watches the goal inputs during play. It emits exactly one single-cycle `p1vic`/`p2vic` pulse per point and stops play when either player reaches the winning score. It sits between the game-field logic (goal detectors, start button) and the scoring block, which consumes `p1vic`/`p2vic` unchanged.

## Interface
- `WIN_POINTS`, 8: points needed to win; legal range 1..8, matching the scoring block's LED capacity.
- `SERVE_CYCLES`, 50_000_000: length of the serve delay in clock cycles; minimum 1.
- `POINT_CYCLES`, 25_000_000: post-point hold in clock cycles; minimum 1.
- `clock`  input  1  system clock.
- `reset`  input  1  asynchronous, active-high.
- `start`  input  1  synchronous, debounced start/serve button, level.
- `p1_goal`  input  1  ball crossed P2's line (point to P1), level.
- `p2_goal`  input  1  ball crossed P1's line (point to P2), level.
- `p1vic`  output  1  one-cycle point pulse for P1 to the scoring block.
- `p2vic`  output  1  one-cycle point pulse for P2 to the scoring block.
- `round_active`  output  1  ball in play; high only in PLAY.
- `serve_p2`  output  1  0 = P1 serves, 1 = P2 serves.
- `match_over`  output  1  a player has reached `WIN_POINTS`.
- `winner`  output  1  0 = P1, 1 = P2; valid while `match_over` = 1.

## Operation
- States:
  - IDLE → SERVE when `start` rises; the rise is detected from a registered copy of `start`.
  - SERVE → PLAY when the timer expires.
  - PLAY → POINT when `p1_goal` or `p2_goal` is sampled high.
  - POINT → SERVE after `POINT_CYCLES`, or POINT → OVER if a score reached `WIN_POINTS`.
  - OVER → IDLE on a `start` rise; this clears both internal scores.
- Internal scores `s1`, `s2` are `$clog2(WIN_POINTS+1)` bits wide. They mirror the scoring block and never exceed `WIN_POINTS`.
- PLAY with `p1_goal` only:
  - `p1vic` pulses; `s1` increments.
  - `serve_p2` ← 1 (the player who conceded serves next).
- PLAY with `p2_goal` only: symmetric; `serve_p2` ← 0.
- PLAY with both goals in the same cycle: no pulse, scores unchanged, go to POINT (replay). `serve_p2` is unchanged.
- Goal inputs are ignored in IDLE, SERVE, POINT and OVER.
- A `start` rise outside IDLE/OVER is ignored, except under the `_EN` option (see Configuration).
- `winner` latches on entry to OVER and holds until the next IDLE.

## Timing
- Reset values:
  - state IDLE; `s1` = `s2` = 0.
  - `p1vic`, `p2vic`, `round_active`, `serve_p2`, `match_over`, `winner` all 0.
- All outputs are registered.
- `p1vic`/`p2vic` are high in the cycle after the goal is sampled in PLAY, for exactly 1 cycle. A level goal held for many cycles produces one pulse only.
- `round_active` rises the cycle after the SERVE timer expires. It falls the cycle after a goal is sampled, coincident with the pulse.
- Timer reload: the SERVE timer loads `SERVE_CYCLES-1` on entry; the state advances when it reaches 0. The serve phase is therefore exactly `SERVE_CYCLES` cycles. POINT behaves the same with `POINT_CYCLES`.
- `match_over` rises on the same edge the state enters OVER, i.e. `POINT_CYCLES` after the winning pulse.
- Reset asserted mid-match returns to IDLE immediately with the reset values. The scoring block shares `reset`, so both stay consistent.

## Configuration
- `MATCH_CONTROLLER_AUTOSERVE_EN` defined:
  - POINT → SERVE proceeds automatically.
  - The first serve after IDLE still needs `start`.
- `MATCH_CONTROLLER_AUTOSERVE_EN` undefined:
  - POINT goes to a WAIT state after `POINT_CYCLES`.
  - WAIT → SERVE on a `start` rise.
  - `round_active` = 0 in WAIT; goals are ignored in WAIT.
  - OVER is unaffected.

## Structure
- Package `pong_pkg` holds:
  - the `match_state_t` enum (IDLE, SERVE, PLAY, POINT, WAIT, OVER);
  - `MAX_POINTS` = 8, which the scoring block also uses.
- Sub-module `phase_timer`: a loadable down-counter with `load`, `value` and `expired` ports, width `$clog2(max(SERVE_CYCLES, POINT_CYCLES))`. One instance is shared by SERVE and POINT.

## Test plan
All scenarios use `WIN_POINTS`=3, `SERVE_CYCLES`=4, `POINT_CYCLES`=3, AUTOSERVE defined unless noted.
- Reset then idle:
  - Stimulus: hold `p1_goal`=1 for 20 cycles with no `start`.
  - Response: no `p1vic`; `round_active`=0; outputs stay at reset values.
- Single point:
  - Stimulus: `start` pulse; after serve, raise `p1_goal` and hold it 10 cycles.
  - Response: `round_active` high exactly 4 cycles after leaving IDLE; exactly one `p1vic` pulse; `serve_p2`=1.
- Simultaneous goals:
  - Stimulus: in PLAY, raise `p1_goal` and `p2_goal` together.
  - Response: no pulses; re-serve after 3+4 cycles; `serve_p2` unchanged.
- Match win:
  - Stimulus: P2 scores 3 points.
  - Response: three `p2vic` pulses; `match_over`=1 and `winner`=1 3 cycles after the third pulse; further goals produce no pulses.
- Reset mid-play:
  - Stimulus: assert `reset` in PLAY with `s1`=2.
  - Response: all outputs 0 immediately; a new match needs 3 fresh points.
- Without AUTOSERVE:
  - Stimulus: play one point, then give no `start`.
  - Response: the FSM stays in WAIT indefinitely; a `start` rise triggers a serve 4 cycles later.

Source files
------------

// File: rtl/pong_pkg.sv
// pong_pkg: types and constants shared by the match controller and the
// scoring block.
//   match_state_t : match sequencing states
//   MAX_POINTS    : LED capacity of the scoring block (upper limit for WIN_POINTS)
//   timer_width() : phase timer width for the two timed phases; never below 1 bit
package pong_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        WAIT  = 3'd4,
        OVER  = 3'd5
    } match_state_t;

    localparam int MAX_POINTS = 8;

    // The counter holds at most max(a,b)-1, so $clog2(max) bits suffice.
    function automatic int timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/match_controller_phase_timer.sv
// phase_timer: loadable down-counter shared by the SERVE and POINT phases.
// It stops at zero and reports expired while the count is zero.
//   clock   : system clock
//   reset   : asynchronous, active-high
//   load    : load value on the next edge (has priority over counting)
//   value   : reload value (phase length minus one)
//   expired : count is zero
module phase_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/match_controller.sv
// match_controller: sequences a two-player match. It waits for a start press,
// times the serve, watches the goal inputs during play, emits one p1vic/p2vic
// pulse per point and stops when a player reaches WIN_POINTS.
//
// Parameters: WIN_POINTS (1..MAX_POINTS), SERVE_CYCLES (>=1), POINT_CYCLES (>=1).
// Ports:
//   clock, reset          : system clock, asynchronous active-high reset
//   start                 : debounced start/serve button (level)
//   p1_goal / p2_goal     : goal detectors (level), point to P1 / P2
//   p1vic / p2vic         : one-cycle point pulses to the scoring block
//   round_active          : ball in play (PLAY only)
//   serve_p2              : 0 = P1 serves, 1 = P2 serves
//   match_over, winner    : match finished; winner 0 = P1, 1 = P2
// Build option: MATCH_CONTROLLER_AUTOSERVE_EN -- when defined, POINT goes
// straight to SERVE; otherwise it waits in WAIT for a start rise.
//
// state | meaning
// IDLE  | waiting for start rise, scores cleared
// SERVE | serve delay running (SERVE_CYCLES)
// PLAY  | ball in play, goals watched
// POINT | post-point hold (POINT_CYCLES)
// WAIT  | waiting for start rise before next serve
// OVER  | a player reached WIN_POINTS; start rise returns to IDLE
module match_controller
    import pong_pkg::*;
#(
    parameter int WIN_POINTS   = MAX_POINTS,
    parameter int SERVE_CYCLES = 50_000_000,
    parameter int POINT_CYCLES = 25_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic p1_goal,
    input  logic p2_goal,
    output logic p1vic,
    output logic p2vic,
    output logic round_active,
    output logic serve_p2,
    output logic match_over,
    output logic winner
);

    localparam int SCORE_W = $clog2(WIN_POINTS + 1);
    localparam int TW      = timer_width(SERVE_CYCLES, POINT_CYCLES);

    localparam logic [SCORE_W-1:0] WIN_S      = SCORE_W'(WIN_POINTS);
    localparam logic [TW-1:0]      SERVE_LOAD = TW'(SERVE_CYCLES - 1);
    localparam logic [TW-1:0]      POINT_LOAD = TW'(POINT_CYCLES - 1);

    match_state_t       state;
    logic               start_q;
    logic               start_rise;
    logic [SCORE_W-1:0] s1;
    logic [SCORE_W-1:0] s2;
    logic               timer_load;
    logic [TW-1:0]      timer_value;
    logic               timer_expired;

    assign start_rise = start & ~start_q;

    // The timer is held at its reload value in every untimed state, so it is
    // already primed on the edge that enters SERVE or POINT. The only
    // timed-to-timed hand-off is POINT -> SERVE, which reloads on expiry.
    assign timer_load  = !(state == SERVE || state == POINT) ||
                         (state == POINT && timer_expired);
    assign timer_value = (state == PLAY) ? POINT_LOAD : SERVE_LOAD;

    phase_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .load    (timer_load),
        .value   (timer_value),
        .expired (timer_expired)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            start_q      <= 1'b0;
            s1           <= '0;
            s2           <= '0;
            p1vic        <= 1'b0;
            p2vic        <= 1'b0;
            round_active <= 1'b0;
            serve_p2     <= 1'b0;
            match_over   <= 1'b0;
            winner       <= 1'b0;
        end else begin
            start_q <= start;
            p1vic   <= 1'b0;
            p2vic   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_rise) state <= SERVE;
                end
                SERVE: begin
                    if (timer_expired) begin
                        state        <= PLAY;
                        round_active <= 1'b1;
                    end
                end
                PLAY: begin
                    if (p1_goal || p2_goal) begin
                        state        <= POINT;
                        round_active <= 1'b0;
                        // Both goals together is a replay: no score, no serve change.
                        if (p1_goal && !p2_goal) begin
                            p1vic    <= 1'b1;
                            s1       <= s1 + SCORE_W'(1);
                            serve_p2 <= 1'b1;
                        end else if (p2_goal && !p1_goal) begin
                            p2vic    <= 1'b1;
                            s2       <= s2 + SCORE_W'(1);
                            serve_p2 <= 1'b0;
                        end
                    end
                end
                POINT: begin
                    if (timer_expired) begin
                        if (s1 == WIN_S || s2 == WIN_S) begin
                            state      <= OVER;
                            match_over <= 1'b1;
                            winner     <= (s2 == WIN_S);
                        end else begin
`ifdef MATCH_CONTROLLER_AUTOSERVE_EN
                            state <= SERVE;
`else
                            state <= WAIT;
`endif
                        end
                    end
                end
                WAIT: begin
                    if (start_rise) state <= SERVE;
                end
                OVER: begin
                    if (start_rise) begin
                        state      <= IDLE;
                        s1         <= '0;
                        s2         <= '0;
                        match_over <= 1'b0;
                        winner     <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
